fft_sample_ram: RTL
===================

Name: fft_sample_ram

Overview:
- Parametrised sample memory between the AXI host interface and the FFT butterfly core.
- Ownership of the array switches between the host (load/unload) and the core (in-place compute) through a guarded mode-switch state machine.
- Host loads real samples, optionally into bit-reversed addresses. Host and core both get registered reads with a valid strobe.
- Accesses by the non-owner, or issued during a switch, are rejected and flagged.

Parameters:
- HOST_W, 16, host sample width (real part).
- DATA_W, 32, stored word width. Must equal 2*HOST_W; real part in [DATA_W-1:HOST_W], imaginary part in [HOST_W-1:0].
- ADDR_W, 12, address width; depth = 2**ADDR_W.
- SWITCH_CYC, 2, guard cycles spent in SWITCH (range 1..15).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode_req  in  1  requested owner: 1 = host, 0 = core.
- mode_ack  out  1  granted owner: 1 = host, 0 = core.
- switching  out  1  high while in SWITCH.
- bitrev_en  in  1  host writes use the bit-reversed address.
- host_we  in  1  host write request.
- host_re  in  1  host read request.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  HOST_W  host real sample.
- host_rdata  out  DATA_W  host read data.
- host_rvalid  out  1  one-cycle host read-data strobe.
- host_err  out  1  one-cycle host rejection strobe.
- core_we  in  1  core write request.
- core_waddr  in  ADDR_W  core write address.
- core_wdata  in  DATA_W  core write word.
- core_re  in  1  core read request.
- core_raddr  in  ADDR_W  core read address.
- core_rdata  out  DATA_W  core read data.
- core_rvalid  out  1  one-cycle core read-data strobe.
- core_err  out  1  one-cycle core rejection strobe.

Behaviour:
- Reset values: state = HOST, mode_ack = 1, switching = 0, all rdata = 0, all rvalid = 0, all err = 0, switch counter = 0. The memory array is not reset.
- States:
  - HOST: on mode_req = 0, go to SWITCH.
  - CORE: on mode_req = 1, go to SWITCH.
  - SWITCH: counter counts SWITCH_CYC cycles. On the last cycle, go to HOST if mode_req = 1, else CORE; the current mode_req is sampled, so a request that toggles back returns to the old owner.
- mode_ack is registered and updates on entry to HOST or CORE only. It holds its old value during SWITCH.
- switching = 1 exactly for the SWITCH_CYC cycles spent in SWITCH.
- Host port (active only in HOST):
  - host_we stores {host_wdata, HOST_W'b0}.
  - Write address = host_addr, or bit-reversed host_addr (bit i to bit ADDR_W-1-i) when bitrev_en = 1.
  - host_re reads the word at host_addr, never bit-reversed.
  - When host_we and host_re are both high, the write wins, the read is dropped, and there is no error.
- Core port (active only in CORE):
  - Independent write and read in the same cycle.
  - Same-address collision is read-first: core_rdata returns the old word.
- Read latency: 1 cycle. rvalid is high for one cycle after an accepted read. rdata holds its value until the next accepted read on that port.
- Rejection: any we or re on a port that is not the owner, or any access during SWITCH, has no effect on the memory and no effect on rdata. The port's err is high the next cycle for one cycle.
- A read accepted on the last cycle of HOST still returns its data and rvalid in the following cycle (the first SWITCH cycle).
- Asserting rst in any state returns to HOST immediately and discards pending rvalid and err.

Test Plan:
- Assert rst mid-SWITCH, then release -> mode_ack = 1, switching = 0, host_rvalid = core_rvalid = 0, host_rdata = 0.
- HOST, bitrev_en = 0: write 0x005 with 0x1234, then read 0x005 -> next cycle host_rdata = 0x12340000, host_rvalid high for 1 cycle.
- bitrev_en = 1: write addr 0x001 with 0xABCD, then read 0x800 -> host_rdata = 0xABCD0000; addr 0x001 unchanged.
- mode_req 1->0 at cycle t, SWITCH_CYC = 2:
  - switching high in t+1..t+2; mode_ack = 0 from t+3.
  - core_we at t+1 -> core_err at t+2, memory unchanged.
- CORE: core_we to 0x010 with 0xDEADBEEF and core_re of 0x010 in the same cycle (old word 0x12340000) -> core_rdata = 0x12340000; next read of 0x010 returns 0xDEADBEEF.
- CORE: host_we to 0x020 -> host_err high 1 cycle, no write. After returning to HOST, read 0x020 returns its prior contents.

Source files
------------

// File: rtl/fft_sample_ram.sv
// fft_sample_ram: sample memory shared between the AXI host port and the FFT
// butterfly core. A guarded mode-switch FSM hands ownership of the array
// between the two ports. Accesses from the non-owner, or made while a switch
// is in progress, are rejected and flagged with a one-cycle error strobe.
module fft_sample_ram #(
  parameter int HOST_W     = 16,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 12,
  parameter int SWITCH_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_req,
  output logic              mode_ack,
  output logic              switching,
  input  logic              bitrev_en,
  input  logic              host_we,
  input  logic              host_re,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [HOST_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              host_err,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_waddr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              core_re,
  input  logic [ADDR_W-1:0] core_raddr,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_rvalid,
  output logic              core_err
);

  typedef enum logic [1:0] {
    ST_HOST   = 2'd0,
    ST_CORE   = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  localparam int            DEPTH    = 1 << ADDR_W;
  localparam logic [3:0]    LAST_CNT = 4'(SWITCH_CYC - 1);

  // Mirror the address bits: bit i moves to bit ADDR_W-1-i.
  function automatic logic [ADDR_W-1:0] bit_reverse(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      r[i] = a[ADDR_W-1-i];
    end
    return r;
  endfunction

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              mode_ack_q;
  logic              switching_q;

  logic [DATA_W-1:0] mem_q [0:DEPTH-1];

  logic [DATA_W-1:0] host_rdata_q;
  logic              host_rvalid_q;
  logic              host_err_q;
  logic [DATA_W-1:0] core_rdata_q;
  logic              core_rvalid_q;
  logic              core_err_q;

  logic              host_own;
  logic              core_own;
  logic              host_wr_acc;
  logic              host_rd_acc;
  logic              host_rej;
  logic              core_wr_acc;
  logic              core_rd_acc;
  logic              core_rej;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Decide which requests are accepted or rejected this cycle and build the
  // single memory write port (only the owner can ever write).
  always_comb begin
    host_own    = (state_q == ST_HOST);
    core_own    = (state_q == ST_CORE);
    host_wr_acc = host_own & host_we;
    host_rd_acc = host_own & host_re & ~host_we;   // write wins, read dropped
    host_rej    = ~host_own & (host_we | host_re);
    core_wr_acc = core_own & core_we;
    core_rd_acc = core_own & core_re;
    core_rej    = ~core_own & (core_we | core_re);
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    if (host_wr_acc) begin
      wr_en   = 1'b1;
      wr_addr = bitrev_en ? bit_reverse(host_addr) : host_addr;
      wr_data = {host_wdata, {HOST_W{1'b0}}};
    end else if (core_wr_acc) begin
      wr_en   = 1'b1;
      wr_addr = core_waddr;
      wr_data = core_wdata;
    end else begin
      wr_en   = 1'b0;
    end
  end

  // Ownership FSM: guarded SWITCH state, mode_ack only updates on arrival.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HOST;
      cnt_q       <= 4'd0;
      mode_ack_q  <= 1'b1;
      switching_q <= 1'b0;
    end else begin
      case (state_q)
        ST_HOST: begin
          if (!mode_req) begin
            state_q     <= ST_SWITCH;
            cnt_q       <= 4'd0;
            switching_q <= 1'b1;
          end
        end
        ST_CORE: begin
          if (mode_req) begin
            state_q     <= ST_SWITCH;
            cnt_q       <= 4'd0;
            switching_q <= 1'b1;
          end
        end
        ST_SWITCH: begin
          if (cnt_q == LAST_CNT) begin
            cnt_q       <= 4'd0;
            switching_q <= 1'b0;
            // The request is re-sampled here, so a toggle-back returns home.
            state_q     <= mode_req ? ST_HOST : ST_CORE;
            mode_ack_q  <= mode_req;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: begin
          state_q     <= ST_HOST;
          cnt_q       <= 4'd0;
          mode_ack_q  <= 1'b1;
          switching_q <= 1'b0;
        end
      endcase
    end
  end

  // Sample array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Registered read ports and error strobes; core read is read-first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
      host_err_q    <= 1'b0;
      core_rdata_q  <= '0;
      core_rvalid_q <= 1'b0;
      core_err_q    <= 1'b0;
    end else begin
      host_rvalid_q <= host_rd_acc;
      host_err_q    <= host_rej;
      core_rvalid_q <= core_rd_acc;
      core_err_q    <= core_rej;
      if (host_rd_acc) begin
        host_rdata_q <= mem_q[host_addr];
      end
      if (core_rd_acc) begin
        core_rdata_q <= mem_q[core_raddr];
      end
    end
  end

  assign mode_ack    = mode_ack_q;
  assign switching   = switching_q;
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;
  assign host_err    = host_err_q;
  assign core_rdata  = core_rdata_q;
  assign core_rvalid = core_rvalid_q;
  assign core_err    = core_err_q;

endmodule
